// File: rtl/skinny_seq_pkg.sv
// Shared types and widths for the SKINNY-64 masked S-box layer sequencer.
// The widths follow the default layer geometry (16 nibbles, 15-cycle timeout).
package skinny_seq_pkg;

    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned NIBBLES_DEF = 16;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned STATE_W     = NIBBLES_DEF * NIBBLE_W;
    localparam int unsigned IDX_W       = $clog2(NIBBLES_DEF);
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } seq_state_t;

    // Selects one nibble of a single share.
    function automatic logic [NIBBLE_W-1:0] get_nibble(
        input logic [STATE_W-1:0] word,
        input logic [IDX_W-1:0]   idx
    );
        return word[NIBBLE_W * int'(idx) +: NIBBLE_W];
    endfunction

    function automatic logic [STATE_W-1:0] set_nibble(
        input logic [STATE_W-1:0]  word,
        input logic [IDX_W-1:0]    idx,
        input logic [NIBBLE_W-1:0] nib
    );
        logic [STATE_W-1:0] r;
        r = word;
        r[NIBBLE_W * int'(idx) +: NIBBLE_W] = nib;
        return r;
    endfunction

endpackage

// File: rtl/skinny_sbox_layer_seq.sv
// Runs one masked SKINNY-64 S-box layer through a single shared S-box instance,
// one nibble at a time, keeping the two shares strictly separate throughout.
module skinny_sbox_layer_seq
    import skinny_seq_pkg::*;
#(
    parameter int unsigned NIBBLES    = 16,
    parameter int unsigned SB_LATENCY = 6,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] in_s0,
    input  logic [63:0] in_s1,
    output logic [63:0] out_s0,
    output logic [63:0] out_s1,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [3:0]  sb_si_s0,
    output logic [3:0]  sb_si_s1,
    output logic        sb_rst,
    input  logic        sb_synch,
    input  logic [3:0]  sb_so_s0,
    input  logic [3:0]  sb_so_s1,
    output logic        fresh_en
);

    seq_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        in_buf_s0;
    logic [63:0]        in_buf_s1;
    logic [63:0]        res_s0;
    logic [63:0]        res_s1;
    logic [63:0]        res_s0_nxt;
    logic [63:0]        res_s1_nxt;
    logic               nibble_active;

    // Result buffer with the S-box output merged in, used so the final nibble
    // reaches out_* on the same edge that starts DONE.
    always_comb begin
        res_s0_nxt = set_nibble(res_s0, idx, sb_so_s0);
        res_s1_nxt = set_nibble(res_s1, idx, sb_so_s1);
    end

    always_comb begin
        nibble_active = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_CAPTURE);
        sb_si_s0      = nibble_active ? get_nibble(in_buf_s0, idx) : '0;
        sb_si_s1      = nibble_active ? get_nibble(in_buf_s1, idx) : '0;
        fresh_en      = (state == ST_LOAD) || (state == ST_WAIT);
        sb_rst        = rst || (state == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            in_buf_s0 <= '0;
            in_buf_s1 <= '0;
            res_s0    <= '0;
            res_s1    <= '0;
            out_s0    <= '0;
            out_s1    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        in_buf_s0 <= in_s0;
                        in_buf_s1 <= in_s1;
                        idx       <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A synch arriving in the last tolerated cycle still wins.
                    if (sb_synch) begin
                        state <= ST_CAPTURE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    res_s0 <= res_s0_nxt;
                    res_s1 <= res_s1_nxt;
                    if (idx == IDX_W'(NIBBLES - 1)) begin
                        out_s0 <= res_s0_nxt;
                        out_s1 <= res_s1_nxt;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    nominal_latency_seen: cover property (@(posedge clk) disable iff (rst)
        (state == ST_WAIT) && sb_synch && (cnt == CNT_W'(SB_LATENCY - 1)));

    done_excludes_err: assert property (@(posedge clk) disable iff (rst)
        !(done && err));

endmodule

// File: tb/tb_skinny_sbox_layer_seq.sv
// Randomised bench for skinny_sbox_layer_seq with a behavioural masked S-box
// and a whole-layer reference computed on the recombined state.
module tb_skinny_sbox_layer_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] in_s0, in_s1;
    logic [63:0] out_s0, out_s1;
    logic        done, busy, err;
    logic [3:0]  sb_si_s0, sb_si_s1;
    logic        sb_rst;
    logic        sb_synch = 1'b0;
    logic [3:0]  sb_so_s0 = '0;
    logic [3:0]  sb_so_s1 = '0;
    logic        fresh_en;

    int n_cmp = 0;
    int n_err = 0;

    skinny_sbox_layer_seq #(.NIBBLES(16), .SB_LATENCY(6), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_s0(in_s0), .in_s1(in_s1),
        .out_s0(out_s0), .out_s1(out_s1),
        .done(done), .busy(busy), .err(err),
        .sb_si_s0(sb_si_s0), .sb_si_s1(sb_si_s1),
        .sb_rst(sb_rst), .sb_synch(sb_synch),
        .sb_so_s0(sb_so_s0), .sb_so_s1(sb_so_s1),
        .fresh_en(fresh_en)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
            4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
            4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
            4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] ref_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = sbox4(x[i*4 +: 4]);
        return r;
    endfunction

    // Behavioural S-box: captures its input while held in reset, raises synch
    // in the k_synch-th cycle after reset (never when k_synch is 0).
    int          k_synch = 6;
    bit          stray_load = 1'b0;
    bit          mask_chk = 1'b0;
    logic [63:0] op0 = '0, op1 = '0;
    int          li = 0;
    int          si_bad = 0;
    int          leaks = 0;
    int          wcnt = 0;
    logic [3:0]  lat0 = '0, lat1 = '0, m = '0;

    always @(negedge clk) begin
        if (rst) begin
            wcnt = 0;
            sb_synch = 1'b0;
        end else if (sb_rst) begin
            wcnt = 0;
            lat0 = sb_si_s0;
            lat1 = sb_si_s1;
            if (li < 16) begin
                if (sb_si_s0 !== op0[li*4 +: 4] || sb_si_s1 !== op1[li*4 +: 4]) si_bad++;
                if (mask_chk && op1[li*4 +: 4] != 4'h0 &&
                    sb_si_s0 == (op0[li*4 +: 4] ^ op1[li*4 +: 4])) leaks++;
            end
            li++;
            sb_synch = stray_load;
        end else begin
            wcnt++;
            sb_synch = (k_synch != 0) && (wcnt == k_synch);
        end
        m = 4'($urandom);
        sb_so_s0 = sbox4(lat0 ^ lat1) ^ m;
        sb_so_s1 = m;
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Starts one layer at cycle 0 and watches it to done; start2 > 0 pulses a
    // second start with other data in that cycle.
    task automatic run_op(input logic [63:0] a0, input logic [63:0] a1, input int k,
                          input int start2, input logic [63:0] b0, input logic [63:0] b1,
                          output int dc);
        int busy_low;
        busy_low = 0;
        dc = -1;
        @(negedge clk);
        op0 = a0; op1 = a1; li = 0; k_synch = k;
        start = 1'b1; in_s0 = a0; in_s1 = a1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0; in_s0 = rnd64(); in_s1 = rnd64();
                check_val("c1_busy", busy, 1);
                check_val("c1_err_cleared", err, 0);
                check_val("c1_sb_rst", sb_rst, 1);
                check_val("c1_fresh_en", fresh_en, 1);
            end
            if (n == 2) check_val("c2_sb_rst", sb_rst, 0);
            if (n == k + 2 && k > 0) check_val("capture_fresh_en", fresh_en, 0);
            if (n == start2) begin start = 1'b1; in_s0 = b0; in_s1 = b1; end
            if (n == start2 + 1 && start2 > 0) start = 1'b0;
            if (done) begin dc = n; break; end
            if (!busy) busy_low++;
        end
        if (dc < 0) check_val("done_seen", 0, 1);
        check_val("busy_held", busy_low, 0);
        @(negedge clk);
        check_val("done_one_cycle", done, 0);
        check_val("busy_after_done", busy, 0);
    endtask

    initial begin
        int          dc, kk, n_done;
        logic [63:0] a0, a1, r, p0, p1;

        rst = 1'b1; start = 1'b0; in_s0 = '0; in_s1 = '0;
        repeat (3) @(negedge clk);
        check_val("rst_sb_rst", sb_rst, 1);
        check_val("rst_outs", {out_s0 | out_s1}, 0);
        check_val("rst_flags", {done, busy, err, fresh_en}, 0);
        check_val("rst_sb_si", {sb_si_s0, sb_si_s1}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_sb_rst", sb_rst, 0);

        // Unmasked reference vector
        run_op(64'h0123456789ABCDEF, 64'h0, 6, 0, '0, '0, dc);
        check_val("ref_done_cycle", dc, 129);
        check_val("ref_result", out_s0 ^ out_s1, 64'hC6901A2B385D4E7F);

        // Masked reference vector
        r = rnd64();
        mask_chk = 1'b1; leaks = 0;
        run_op(64'h0123456789ABCDEF ^ r, r, 6, 0, '0, '0, dc);
        mask_chk = 1'b0;
        check_val("masked_done_cycle", dc, 129);
        check_val("masked_result", out_s0 ^ out_s1, 64'hC6901A2B385D4E7F);
        check_val("mask_leaks", leaks, 0);

        // Early synch with a stray synch during each LOAD
        a0 = rnd64(); a1 = rnd64();
        stray_load = 1'b1;
        run_op(a0, a1, 3, 0, '0, '0, dc);
        stray_load = 1'b0;
        check_val("early_done_cycle", dc, 81);
        check_val("early_result", out_s0 ^ out_s1, ref_layer(a0 ^ a1));

        // Random operands and latencies over the whole legal range
        for (int t = 0; t < 5; t++) begin
            a0 = rnd64(); a1 = rnd64();
            kk = (t == 0) ? 15 : ((t == 1) ? 1 : int'($urandom_range(1, 15)));
            run_op(a0, a1, kk, 0, '0, '0, dc);
            check_val("rand_done_cycle", dc, 1 + 16 * (kk + 2));
            check_val("rand_result", out_s0 ^ out_s1, ref_layer(a0 ^ a1));
        end

        // Timeout: no synch ever
        p0 = out_s0; p1 = out_s1; n_done = 0;
        @(negedge clk);
        op0 = rnd64(); op1 = rnd64(); li = 0; k_synch = 0;
        start = 1'b1; in_s0 = op0; in_s1 = op1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 16) check_val("to_c16", {err, busy}, 2'b01);
            if (n == 17) check_val("to_c17", {err, busy}, 2'b10);
            if (done) n_done++;
        end
        check_val("to_no_done", n_done, 0);
        check_val("to_out_s0_kept", out_s0, p0);
        check_val("to_out_s1_kept", out_s1, p1);
        check_val("to_err_sticky", err, 1);
        a0 = rnd64(); a1 = rnd64();
        run_op(a0, a1, 6, 0, '0, '0, dc);
        check_val("after_to_err", err, 0);
        check_val("after_to_result", out_s0 ^ out_s1, ref_layer(a0 ^ a1));

        // Reset in cycle 50 of an operation
        @(negedge clk);
        op0 = rnd64(); op1 = rnd64(); li = 0; k_synch = 6;
        start = 1'b1; in_s0 = op0; in_s1 = op1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_outs", {out_s0, out_s1} != '0, 0);
        check_val("mid_rst_sb_si", {sb_si_s0, sb_si_s1}, 0);
        check_val("mid_rst_sb_rst", sb_rst, 1);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_idle", {busy, done, sb_rst, fresh_en}, 0);

        // Start during busy is ignored
        a0 = rnd64(); a1 = rnd64();
        run_op(a0, a1, 6, 40, rnd64(), rnd64(), dc);
        check_val("busy_prot_done_cycle", dc, 129);
        check_val("busy_prot_result", out_s0 ^ out_s1, ref_layer(a0 ^ a1));

        check_val("sb_si_routing", si_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/skinny_sbox_layer_seq.md
# skinny_sbox_layer_seq

Sequencer that applies one masked SKINNY-64 S-box layer to a 2-share 64-bit state. It uses a single shared masked S-box instance (GHPC gadgets with clock-gating controller, latency 6, d=1) once per nibble. It sits between the round datapath and the S-box. It drives the S-box's input shares and synchronous reset, consumes its `Synch` pulse, collects the 16 output nibbles, and returns the full shared state with a one-cycle `done`.

## Interface
- `NIBBLES`, 16, number of nibbles processed per layer
- `SB_LATENCY`, 6, nominal S-box latency in WAIT cycles (informational, used by assertions)
- `TIMEOUT`, 15, maximum WAIT cycles tolerated before error
- `clk` in 1: system clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: request; accepted only in IDLE
- `in_s0`, `in_s1` in 64 each: state shares, sampled on the accepted `start`
- `out_s0`, `out_s1` out 64 each: result shares
- `done` out 1: one-cycle pulse when outputs update
- `busy` out 1: high from accept through DONE
- `err` out 1: sticky timeout flag
- `sb_si_s0`, `sb_si_s1` out 4 each: S-box input shares
- `sb_rst` out 1: S-box controller reset
- `sb_synch` in 1: S-box output-valid pulse
- `sb_so_s0`, `sb_so_s1` in 4 each: S-box output shares
- `fresh_en` out 1: PRNG advance enable

## Operation
- Shares are never combined. There is no XOR, mux or compare between s0 and s1 anywhere in the block.
- FSM states: IDLE, LOAD, WAIT, CAPTURE, DONE.
- **IDLE**
  - On `start`: latch `in_s0`/`in_s1` into the input buffer, set idx=0, clear `err`, go to LOAD.
  - `start` in any other state is ignored.
- **LOAD** (1 cycle)
  - Drive `sb_si` with nibble idx (bits 4·idx+3 : 4·idx) of each share.
  - Assert `sb_rst`, set cnt=0, go to WAIT.
- **WAIT**
  - `sb_si` is held stable; `sb_rst` is low; cnt increments each cycle.
  - If `sb_synch`=1, go to CAPTURE. Any WAIT cycle counts, including early ones.
  - Otherwise, if cnt = TIMEOUT−1, set `err`=1 and go to IDLE. No `done` is issued, and `out_*` and idx are left unchanged.
- **CAPTURE** (1 cycle)
  - Write `sb_so_s0`/`sb_so_s1` into nibble idx of the result buffer.
  - If idx = NIBBLES−1, load `out_*` from the result buffer and go to DONE.
  - Otherwise increment idx and go to LOAD.
- **DONE** (1 cycle): `done`=1, then go to IDLE.
- `sb_synch` outside WAIT is ignored.
- `sb_si_s0`/`sb_si_s1` are driven to 0 in IDLE and DONE. In LOAD, WAIT and CAPTURE they present the current nibble.
- `fresh_en` = 1 in LOAD and WAIT, 0 otherwise.
- `sb_rst` = `rst` OR (state = LOAD).
- Reset values: state IDLE; `out_*` = 0; `done`, `busy`, `err`, `fresh_en` = 0; `sb_si_*` = 0; `sb_rst` = 1 while `rst` is high.
- Reset mid-operation aborts immediately and discards partial results; `out_*` returns to 0.

## Timing
- Cycle 0: `start` accepted.
- Nibble i: LOAD in cycle 1+8i, WAIT in cycles 2+8i to 7+8i (`sb_synch` nominally in 7+8i), CAPTURE in cycle 8+8i.
- Nominal `done` is in cycle 129; `busy` is high in cycles 1–129.
- General per-nibble cost is k+2 cycles, where k is the WAIT cycle in which `sb_synch` arrives (1 ≤ k ≤ TIMEOUT).
- Timeout: `err` rises TIMEOUT+1 cycles after the LOAD cycle, and `busy` falls in the same cycle.
- `out_*` changes only on the edge that starts DONE, or on reset.

## Structure
- Package `skinny_seq_pkg` holds:
  - the state enum;
  - NIBBLE_W=4;
  - the nibble index width, $clog2(NIBBLES);
  - the count width, $clog2(TIMEOUT+1).
- Single module; no sub-module is required. The S-box instance sits outside the block, in the layer top.

## Test plan
- Unmasked reference: with a behavioural S-box model (`sb_synch` asserted in the 6th WAIT cycle), apply in_s0=64'h0123456789ABCDEF, in_s1=0 → `done` in cycle 129 and out_s0^out_s1 = 64'hC6901A2B385D4E7F.
- Masked input: in_s1=R (random), in_s0=64'h0123456789ABCDEF^R → same recombined result; `sb_si_s0` never equals the unmasked nibble when R's nibble ≠0, checked by assertion.
- Early synch: model asserts `sb_synch` in the 3rd WAIT cycle → `done` in cycle 81 with the correct result; a stray `sb_synch` during LOAD changes nothing.
- Timeout: model never asserts `sb_synch` → `err`=1 and `busy`=0 in cycle 17; no `done`; `out_*` remains at its previous value; the next `start` clears `err`.
- Reset mid-op: `rst` in cycle 50 → in cycle 51 `busy`=0, `out_*`=0, `sb_si_*`=0; `sb_rst` is high during the `rst` cycles.
- Busy protection: `start` pulsed at cycle 40 with different data → ignored; the result matches the first operand.
